// File: rtl/cpu_cegen.sv
// Multi-phase clock-enable generator: 2-phase CPU edge strobes with a wait-state hold,
// plus free-running auxiliary clock-enable channels, all derived from the master clock.
module cpu_cegen #(
  parameter int unsigned          DIV      = 14,
  parameter int unsigned          CP2N_AT  = 0,
  parameter int unsigned          CP1P_AT  = 2,
  parameter int unsigned          CP1N_AT  = 4,
  parameter int unsigned          CP2P_AT  = 6,
  parameter int unsigned          STALL_AT = 5,
  parameter int unsigned          NAUX     = 1,
  parameter logic [NAUX*5-1:0]    AUX_DIV  = {5'd7},
  parameter logic [NAUX*5-1:0]    AUX_OFS  = {5'd2}
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            STALL,
  input  logic [NAUX-1:0] AUX_EN,
  output logic            CP1_POSEDGE,
  output logic            CP1_NEGEDGE,
  output logic            CP2_POSEDGE,
  output logic            CP2_NEGEDGE,
  output logic [NAUX-1:0] AUX_CE,
  output logic [4:0]      PHASE,
  output logic            STALLED
);

  localparam int unsigned CW = 5;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CP2N_POS  = CW'(CP2N_AT);
  localparam logic [CW-1:0] CP1P_POS  = CW'(CP1P_AT);
  localparam logic [CW-1:0] CP1N_POS  = CW'(CP1N_AT);
  localparam logic [CW-1:0] CP2P_POS  = CW'(CP2P_AT);
  localparam logic [CW-1:0] STALL_POS = CW'(STALL_AT);

  // Configuration sanity, rejected at elaboration
  if (DIV < 4 || DIV > 31) begin : g_bad_div
    $fatal(1, "cpu_cegen: DIV must be 4..31");
  end
  if (CP2N_AT >= DIV || CP1P_AT >= DIV || CP1N_AT >= DIV ||
      CP2P_AT >= DIV || STALL_AT >= DIV) begin : g_bad_pos
    $fatal(1, "cpu_cegen: phase positions must be below DIV");
  end
  if (CP2N_AT == CP1P_AT || CP2N_AT == CP1N_AT || CP2N_AT == CP2P_AT ||
      CP2N_AT == STALL_AT || CP1P_AT == CP1N_AT || CP1P_AT == CP2P_AT ||
      CP1P_AT == STALL_AT || CP1N_AT == CP2P_AT || CP1N_AT == STALL_AT ||
      CP2P_AT == STALL_AT) begin : g_dup_pos
    $fatal(1, "cpu_cegen: phase positions must be distinct");
  end
  if (NAUX < 1 || NAUX > 8) begin : g_bad_naux
    $fatal(1, "cpu_cegen: NAUX must be 1..8");
  end

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          hold_c;

  // CPU phase counter next state; a stall request only bites at the stall position
  always_comb begin
    hold_c = run_q & STALL & (cnt_q == STALL_POS);
    cnt_d  = cnt_q;
    if (run_q && !hold_c) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign CP2_NEGEDGE = run_q & (cnt_q == CP2N_POS);
  assign CP1_POSEDGE = run_q & (cnt_q == CP1P_POS);
  assign CP1_NEGEDGE = run_q & (cnt_q == CP1N_POS);
  assign CP2_POSEDGE = run_q & (cnt_q == CP2P_POS);
  assign PHASE       = cnt_q;
  assign STALLED     = hold_c;

  // Auxiliary channels run on their own counters and ignore the CPU stall
  for (genvar g = 0; g < NAUX; g++) begin : g_aux
    localparam logic [CW-1:0] ADIV = AUX_DIV[g*5 +: 5];
    localparam logic [CW-1:0] AOFS = AUX_OFS[g*5 +: 5];
    localparam logic [CW-1:0] ALAST = ADIV - CW'(1);

    if (ADIV < CW'(2) || AOFS >= ADIV) begin : g_bad_aux
      $fatal(1, "cpu_cegen: AUX_DIV must be 2..31 and AUX_OFS below it");
    end

    logic [CW-1:0] acnt_q;
    logic [CW-1:0] acnt_d;

    always_comb begin
      acnt_d = acnt_q;
      if (run_q && AUX_EN[g]) begin
        acnt_d = (acnt_q == ALAST) ? '0 : acnt_q + CW'(1);
      end
    end

    always_ff @(posedge CLK) begin
      if (RES) begin
        acnt_q <= '0;
      end else begin
        acnt_q <= acnt_d;
      end
    end

    assign AUX_CE[g] = run_q & AUX_EN[g] & (acnt_q == AOFS);
  end

endmodule

// File: tb/tb_cpu_cegen.sv
// Bench for cpu_cegen: default and non-default instances checked every cycle against a
// cycle-count model, plus hand-computed traces and intervals.
module tb_cpu_cegen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res_a, stall_a, res_b, stall_b;
  logic [0:0] en_a;
  logic [1:0] en_b;

  logic       a_cp1p, a_cp1n, a_cp2p, a_cp2n, a_st;
  logic [0:0] a_aux;
  logic [4:0] a_ph;
  logic       b_cp1p, b_cp1n, b_cp2p, b_cp2n, b_st;
  logic [1:0] b_aux;
  logic [4:0] b_ph;

  cpu_cegen u_a (
    .CLK(clk), .RES(res_a), .STALL(stall_a), .AUX_EN(en_a),
    .CP1_POSEDGE(a_cp1p), .CP1_NEGEDGE(a_cp1n), .CP2_POSEDGE(a_cp2p), .CP2_NEGEDGE(a_cp2n),
    .AUX_CE(a_aux), .PHASE(a_ph), .STALLED(a_st)
  );

  cpu_cegen #(
    .DIV(10), .CP2N_AT(0), .CP1P_AT(3), .CP1N_AT(5), .CP2P_AT(8), .STALL_AT(9),
    .NAUX(2), .AUX_DIV({5'd3, 5'd5}), .AUX_OFS({5'd1, 5'd0})
  ) u_b (
    .CLK(clk), .RES(res_b), .STALL(stall_b), .AUX_EN(en_b),
    .CP1_POSEDGE(b_cp1p), .CP1_NEGEDGE(b_cp1n), .CP2_POSEDGE(b_cp2p), .CP2_NEGEDGE(b_cp2n),
    .AUX_CE(b_aux), .PHASE(b_ph), .STALLED(b_st)
  );

  // Configuration of both instances: strobe positions in order cp2n, cp1p, cp1n, cp2p
  int div_c   [2]    = '{14, 10};
  int pos_c   [2][4] = '{'{0, 2, 4, 6}, '{0, 3, 5, 8}};
  int stall_c [2]    = '{5, 9};
  int naux_c  [2]    = '{1, 2};
  int adiv_c  [2][2] = '{'{7, 1}, '{5, 3}};
  int aofs_c  [2][2] = '{'{2, 0}, '{0, 1}};

  // Model: run flag plus counts of advancing cycles since reset
  bit m_run  [2]    = '{0, 0};
  int m_adv  [2]    = '{0, 0};
  int m_aadv [2][2] = '{'{0, 0}, '{0, 0}};
  int tcyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic get_res(int d);   return d == 0 ? res_a : res_b;     endfunction
  function automatic logic get_stall(int d); return d == 0 ? stall_a : stall_b; endfunction
  function automatic logic [1:0] get_en(int d);  return d == 0 ? {1'b0, en_a} : en_b;   endfunction
  function automatic logic [1:0] get_aux(int d); return d == 0 ? {1'b0, a_aux} : b_aux; endfunction
  function automatic logic [4:0] get_ph(int d);  return d == 0 ? a_ph : b_ph;           endfunction
  function automatic logic get_st(int d);    return d == 0 ? a_st : b_st;       endfunction
  function automatic logic [3:0] get_cp(int d);
    return d == 0 ? {a_cp2p, a_cp1n, a_cp1p, a_cp2n} : {b_cp2p, b_cp1n, b_cp1p, b_cp2n};
  endfunction
  function automatic int mph(int d);         return m_adv[d] % div_c[d];                 endfunction
  function automatic int maux(int d, int i); return m_aadv[d][i] % adiv_c[d][i];         endfunction

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, tcyc, got, exp);
    end
  endtask

  always @(posedge clk) begin
    tcyc <= tcyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (get_res(d)) begin
        m_run[d]     <= 1'b0;
        m_adv[d]     <= 0;
        m_aadv[d][0] <= 0;
        m_aadv[d][1] <= 0;
      end else begin
        if (m_run[d] && !(get_stall(d) && mph(d) == stall_c[d])) m_adv[d] <= m_adv[d] + 1;
        for (int i = 0; i < 2; i++)
          if (m_run[d] && get_en(d)[i]) m_aadv[d][i] <= m_aadv[d][i] + 1;
        m_run[d] <= 1'b1;
      end
    end
  end

  // Interval monitors on instance A for the hand-computed checks
  int a_st_cnt = 0, a_aux_cnt = 0;
  int cp2n_last = 0, cp2n_gap = 0, cp1n_last = 0, cp2p_last = 0;
  int aux_last = 0, aux_gap = 0, gmin = 1000, gmax = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++)
        check($sformatf("d%0d.cp%0d", d, k), int'(get_cp(d)[k]),
              int'(m_run[d] && mph(d) == pos_c[d][k]));
      check($sformatf("d%0d.phase", d), int'(get_ph(d)), mph(d));
      check($sformatf("d%0d.stalled", d), int'(get_st(d)),
            int'(m_run[d] && get_stall(d) && mph(d) == stall_c[d]));
      for (int i = 0; i < naux_c[d]; i++)
        check($sformatf("d%0d.aux%0d", d, i), int'(get_aux(d)[i]),
              int'(m_run[d] && get_en(d)[i] && maux(d, i) == aofs_c[d][i]));
    end
    if (a_st) a_st_cnt <= a_st_cnt + 1;
    if (a_cp2n) begin cp2n_gap <= tcyc - cp2n_last; cp2n_last <= tcyc; end
    if (a_cp1n) cp1n_last <= tcyc;
    if (a_cp2p) cp2p_last <= tcyc;
    if (a_aux[0]) begin
      a_aux_cnt <= a_aux_cnt + 1;
      aux_gap   <= tcyc - aux_last;
      aux_last  <= tcyc;
      if (tcyc - aux_last < gmin) gmin <= tcyc - aux_last;
      if (tcyc - aux_last > gmax) gmax <= tcyc - aux_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ph(input int d, input int p);
    for (int k = 0; k < 64; k++) begin
      step();
      if (mph(d) == p) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_ph d%0d timeout got=%0d exp=%0d", d, mph(d), p);
  endtask

  task automatic wait_acnt(input int d, input int i, input int v);
    for (int k = 0; k < 64; k++) begin
      step();
      if (maux(d, i) == v) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_acnt timeout got=%0d exp=%0d", maux(d, i), v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=%0d exp=0", tcyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] t_cp2n, t_cp1p, t_cp1n, t_cp2p, t_aux;
    logic [25:0] u_cp2n, u_cp1p, u_cp1n, u_cp2p, u_aux0, u_aux1;
    int st0, ac0, n;

    res_a = 1'b1; res_b = 1'b1; stall_a = 1'b0; stall_b = 1'b0;
    en_a = 1'b1; en_b = 2'b11;
    t_cp2n = '0; t_cp1p = '0; t_cp1n = '0; t_cp2p = '0; t_aux = '0;
    u_cp2n = '0; u_cp1p = '0; u_cp1n = '0; u_cp2p = '0; u_aux0 = '0; u_aux1 = '0;

    // Reset held for three cycles: everything quiet
    repeat (3) begin
      step();
      check("rst.a_out", int'({get_cp(0), a_aux, a_st}), 0);
      check("rst.a_phase", int'(a_ph), 0);
    end

    // Release and trace the first 20 cycles of the default sequence
    res_a = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      t_cp2n[c] = a_cp2n; t_cp1p[c] = a_cp1p; t_cp1n[c] = a_cp1n;
      t_cp2p[c] = a_cp2p; t_aux[c]  = a_aux[0];
    end
    check("a.trace_cp2n", int'(t_cp2n), 21'h008002);
    check("a.trace_cp1p", int'(t_cp1p), 21'h020008);
    check("a.trace_cp1n", int'(t_cp1n), 21'h080020);
    check("a.trace_cp2p", int'(t_cp2p), 21'h000080);
    check("a.trace_aux",  int'(t_aux),  21'h020408);

    // Stall raised at phase 3, held for ten stalled cycles
    wait_ph(0, 3);
    st0 = a_st_cnt;
    gmin = 1000; gmax = 0;
    stall_a = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (mph(0) == 5) begin
        if (n == 10) begin
          stall_a = 1'b0;
          break;
        end
        n++;
      end
    end
    wait_ph(0, 7);
    check("stall.cycles", a_st_cnt - st0, 10);
    check("stall.cp2p_delay", cp2p_last - cp1n_last, 12);
    check("stall.aux_gap_min", gmin, 7);
    check("stall.aux_gap_max", gmax, 7);

    // One-cycle stall pulse away from the stall position
    wait_ph(0, 0);
    wait_ph(0, 8);
    st0 = a_st_cnt;
    stall_a = 1'b1;
    step();
    stall_a = 1'b0;
    wait_ph(0, 1);
    check("offpos.stalled", a_st_cnt - st0, 0);
    check("offpos.period", cp2n_gap, 14);

    // Aux channel frozen for four cycles starting at count 1
    wait_acnt(0, 0, 1);
    ac0 = a_aux_cnt;
    en_a = 1'b0;
    repeat (4) step();
    en_a = 1'b1;
    step();
    check("auxen.silent", a_aux_cnt - ac0, 0);
    step();
    check("auxen.gap", aux_gap, 11);

    // Single-cycle reset at phase 9, then restart
    wait_ph(0, 9);
    res_a = 1'b1;
    step();
    check("midrst.cp", int'(get_cp(0)), 0);
    check("midrst.phase", int'(a_ph), 0);
    res_a = 1'b0;
    step();
    check("restart.cp2n", int'(get_cp(0)), 4'b0001);
    check("restart.phase", int'(a_ph), 0);
    step();
    step();
    check("restart.cp1p", int'(get_cp(0)), 4'b0010);
    check("restart.aux", int'(a_aux), 1);

    // Non-default instance: trace after release
    res_b = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      step();
      u_cp2n[c] = b_cp2n; u_cp1p[c] = b_cp1p; u_cp1n[c] = b_cp1n;
      u_cp2p[c] = b_cp2p; u_aux0[c] = b_aux[0]; u_aux1[c] = b_aux[1];
    end
    check("b.trace_cp2n", int'(u_cp2n), 26'h0200802);
    check("b.trace_cp1p", int'(u_cp1p), 26'h1004010);
    check("b.trace_cp1n", int'(u_cp1n), 26'h0010040);
    check("b.trace_cp2p", int'(u_cp2p), 26'h0080200);
    check("b.trace_aux0", int'(u_aux0), 26'h0210842);
    check("b.trace_aux1", int'(u_aux1), 26'h0924924);

    // Non-default stall holds at 9 and resumes into phase 0
    wait_ph(1, 7);
    stall_b = 1'b1;
    wait_ph(1, 9);
    repeat (3) step();
    check("b.stall_phase", int'(b_ph), 9);
    check("b.stalled", int'(b_st), 1);
    stall_b = 1'b0;
    step();
    check("b.resume_phase", int'(b_ph), 0);
    check("b.resume_cp2n", int'(b_cp2n), 1);

    repeat (30) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
